// File: rtl/key_accumulator.sv
// Debounced pushbutton accumulator: KEY[1] adds SW to a running sum, KEY[2] clears it.
// Define KEY_ACCUMULATOR_SATURATE_EN to saturate on overflow instead of wrapping.
module key_accumulator #(
   parameter int DATA_W   = 8,
   parameter int ACC_W    = 9,
   parameter int DEBOUNCE = 500000
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic [3:0] KEY,
   input  logic [9:0] SW,
   output logic [9:0] LEDR
);

   localparam int              CNT_W    = $clog2(DEBOUNCE + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

   typedef enum logic [1:0] {
      ST_UP,
      ST_DN_CNT,
      ST_DOWN,
      ST_UP_CNT
   } db_state_e;

   // Bit 0 tracks the add key (KEY[1]), bit 1 the clear key (KEY[2]).
   logic [1:0]        key_meta_q, key_sync_q;
   logic [DATA_W-1:0] sw_meta_q, sw_sync_q;

   logic unused_inputs;
   assign unused_inputs = ^{KEY[3], KEY[0], SW};

   // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         key_meta_q <= 2'b11;
         key_sync_q <= 2'b11;
         sw_meta_q  <= '0;
         sw_sync_q  <= '0;
      end else begin
         key_meta_q <= {KEY[2], KEY[1]};
         key_sync_q <= key_meta_q;
         sw_meta_q  <= SW[DATA_W-1:0];
         sw_sync_q  <= sw_meta_q;
      end
   end

   logic [1:0] press;

   for (genvar g = 0; g < 2; g++) begin : g_db
      db_state_e        state_q, state_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             press_q, press_d;
      logic             key_low;

      assign key_low  = ~key_sync_q[g];
      assign press[g] = press_q;

      always_ff @(posedge CLOCK_50 or posedge reset) begin
         if (reset) begin
            state_q <= ST_UP;
            cnt_q   <= '0;
            press_q <= 1'b0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
         end
      end

      // NOTE: defaults first so no path through the case leaves a signal unassigned (no latch).
      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         press_d = 1'b0;
         unique case (state_q)
            ST_UP: begin
               if (key_low) begin
                  state_d = ST_DN_CNT;
                  cnt_d   = CNT_W'(1);
               end
            end
            ST_DN_CNT: begin
               if (!key_low) begin
                  state_d = ST_UP;
                  cnt_d   = '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_d = ST_DOWN;
                  cnt_d   = '0;
                  press_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_DOWN: begin
               if (!key_low) begin
                  state_d = ST_UP_CNT;
                  cnt_d   = CNT_W'(1);
               end
            end
            ST_UP_CNT: begin
               if (key_low) begin
                  state_d = ST_DOWN;
                  cnt_d   = '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_d = ST_UP;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: begin
               state_d = ST_UP;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // The pulse cycle's SW value is latched alongside the request; the sum updates one edge later.
   logic              add_q, clr_q;
   logic [DATA_W-1:0] op_q;
   logic [ACC_W-1:0]  sum_q, sum_d;
   logic              ovf_q, ovf_d;
   logic [ACC_W:0]    sum_ext;

   assign sum_ext = {1'b0, sum_q} + {{(ACC_W + 1 - DATA_W){1'b0}}, op_q};

   always_comb begin
      sum_d = sum_q;
      ovf_d = ovf_q;
      if (clr_q) begin
         sum_d = '0;
         ovf_d = 1'b0;
      end else if (add_q) begin
         sum_d = sum_ext[ACC_W-1:0];
         if (sum_ext[ACC_W]) begin
            ovf_d = 1'b1;
`ifdef KEY_ACCUMULATOR_SATURATE_EN
            sum_d = '1;
`else
            sum_d = sum_ext[ACC_W-1:0];
`endif
         end
      end
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         add_q <= 1'b0;
         clr_q <= 1'b0;
         op_q  <= '0;
         sum_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         add_q <= press[0];
         clr_q <= press[1];
         op_q  <= sw_sync_q;
         sum_q <= sum_d;
         ovf_q <= ovf_d;
      end
   end

   always_comb begin
      LEDR              = '0;
      LEDR[ACC_W-1:0]   = sum_q;
      LEDR[9]           = ovf_q;
   end

endmodule

// File: tb/tb_key_accumulator.sv
// Directed bench for key_accumulator at DEBOUNCE=4, DATA_W=8, ACC_W=9.
module tb_key_accumulator;

   localparam int D = 4;

   logic       clk;
   logic       rst;
   logic [3:0] key;
   logic [9:0] sw;
   logic [9:0] ledr;

   int checks = 0;
   int errors = 0;

   key_accumulator #(.DATA_W(8), .ACC_W(9), .DEBOUNCE(D)) dut (
      .CLOCK_50 (clk),
      .reset    (rst),
      .KEY      (key),
      .SW       (sw),
      .LEDR     (ledr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [9:0] actual, input logic [9:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0d (0x%03h) expected %0d (0x%03h)", name, actual, actual,
                  expected, expected);
      end
   endtask

   // Hold the keys in mask (1 = pressed) for hold cycles, release, then let the debouncers settle.
   task automatic press(input logic [3:0] mask, input logic [9:0] sw_val, input int hold);
      @(negedge clk);
      sw  = sw_val;
      key = ~mask;
      repeat (hold) @(negedge clk);
      key = 4'hF;
      repeat (2 * D + 10) @(negedge clk);
   endtask

   typedef struct {
      string      name;
      logic [3:0] mask;
      logic [9:0] sw_val;
      logic [9:0] exp_ledr;
   } vec_t;

   vec_t vecs[10];

   initial begin
`ifdef KEY_ACCUMULATOR_SATURATE_EN
      vecs[3] = '{"add_250_ovf", 4'b0010, 10'd250, 10'h3FF};
      vecs[4] = '{"add_1_sat",   4'b0010, 10'd1,   10'h3FF};
`else
      vecs[3] = '{"add_250_ovf", 4'b0010, 10'd250, 10'h200 | 10'd38};
      vecs[4] = '{"add_1_wrap",  4'b0010, 10'd1,   10'h200 | 10'd39};
`endif
      vecs[0] = '{"clear",       4'b0100, 10'd0,   10'd0};
      vecs[1] = '{"add_200",     4'b0010, 10'd200, 10'd200};
      vecs[2] = '{"add_100",     4'b0010, 10'd100, 10'd300};
      vecs[5] = '{"clear_ovf",   4'b0100, 10'd0,   10'd0};
      vecs[6] = '{"add_and_clr", 4'b0110, 10'd7,   10'd0};
      vecs[7] = '{"add_7",       4'b0010, 10'd7,   10'd7};
      vecs[8] = '{"add_sw_hi",   4'b0010, 10'h3FF, 10'd262};
      vecs[9] = '{"ignored_key", 4'b1001, 10'd9,   10'd262};

      rst = 1'b1;
      key = 4'hF;
      sw  = '0;
      repeat (3) @(negedge clk);
      check("reset_held", ledr, 10'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_released", ledr, 10'd0);

      // Single press: the sum must change on exactly the (D+4)th edge from the first low sample.
      sw = 10'd5;
      repeat (3) @(negedge clk);
      key = 4'b1101;
      for (int e = 1; e <= D + 4; e++) begin
         @(posedge clk);
         #1;
         if (e == D + 3) check("latency_before", ledr, 10'd0);
         if (e == D + 4) check("latency_at",     ledr, 10'd5);
      end
      repeat (50 - (D + 4)) @(negedge clk);
      key = 4'hF;
      repeat (100) @(negedge clk);
      check("held_release", ledr, 10'd5);

      // Bounce: lows shorter than D synced cycles never produce a pulse.
      sw = 10'd3;
      for (int i = 0; i < 20; i++) begin
         key = 4'b1101;
         repeat (3) @(negedge clk);
         key = 4'hF;
         @(negedge clk);
      end
      repeat (20) @(negedge clk);
      check("bounce_reject", ledr, 10'd5);
      press(4'b0010, 10'd3, 10);
      check("bounce_clean", ledr, 10'd8);

      for (int i = 0; i < 10; i++) begin
         press(vecs[i].mask, vecs[i].sw_val, 10);
         check(vecs[i].name, ledr, vecs[i].exp_ledr);
      end

      // Reset mid-debounce clears immediately; a key still held afterwards counts as a new press.
      press(4'b0100, 10'd0, 10);
      press(4'b0010, 10'd5, 10);
      check("pre_mid_reset", ledr, 10'd5);
      @(negedge clk);
      key = 4'b1101;
      repeat (4) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("async_reset", ledr, 10'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int e = 1; e <= D + 4; e++) begin
         @(posedge clk);
         #1;
         if (e == D + 3) check("held_reset_before", ledr, 10'd0);
         if (e == D + 4) check("held_reset_at",     ledr, 10'd5);
      end
      repeat (10) @(negedge clk);
      key = 4'hF;
      repeat (30) @(negedge clk);
      check("held_reset_once", ledr, 10'd5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
